// File: rtl/shift_right_seq_if.sv
// Request/result bundle for the sequential 16-bit right shifter/rotator.
// The master drives the request and operands; the slave returns the result and status.
interface shift_right_seq_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OP_W   = 2;

    logic              start;
    logic [DATA_W-1:0] in;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] out;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output in,
        output cnt,
        output op,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  in,
        input  cnt,
        input  op,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_right_seq.sv
// Four-stage log-shifter run sequentially: stage k moves the work word right by 2^k
// when cnt[k] is set, so every operation takes the same 4 RUN cycles plus one DONE cycle.
module shift_right_seq (
    input  logic            clk,
    input  logic            rst_n,
    shift_right_seq_if.slave if_bus
);
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned STAGE_W = 2;
    localparam int unsigned AMT_W   = 5;

    localparam logic [OP_W-1:0]    OP_LSR     = 2'b01;
    localparam logic [OP_W-1:0]    OP_ASR     = 2'b10;
    localparam logic [STAGE_W-1:0] LAST_STAGE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STAGE_W-1:0]  r_stage;
    logic [STAGE_W-1:0]  w_stage_nxt;
    logic [DATA_W-1:0]   r_work;
    logic [DATA_W-1:0]   w_work_nxt;
    logic [DATA_W-1:0]   r_out;
    logic [DATA_W-1:0]   w_out_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_W-1:0]     r_op;
    logic                r_sign;
    logic                r_busy;
    logic                r_done;
    logic                w_capture;

    logic [AMT_W-1:0]    w_amt;
    logic [DATA_W-1:0]   w_shr;
    logic [DATA_W-1:0]   w_wrap;
    logic [DATA_W-1:0]   w_sign_fill;
    logic [DATA_W-1:0]   w_moved;
    logic [DATA_W-1:0]   w_stage_res;

    // One shifter stage: amount is 2^stage, fill depends on the captured op.
    always_comb begin
        w_amt       = AMT_W'(1) << r_stage;
        w_shr       = r_work >> w_amt;
        w_wrap      = r_work << (AMT_W'(DATA_W) - w_amt);
        w_sign_fill = ~({DATA_W{1'b1}} >> w_amt) & {DATA_W{r_sign}};
        case (r_op)
            OP_LSR:  w_moved = w_shr;
            OP_ASR:  w_moved = w_shr | w_sign_fill;
            default: w_moved = w_shr | w_wrap;
        endcase
        w_stage_res = r_cnt[r_stage] ? w_moved : r_work;
    end

    // Next-state and datapath-update decode.
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_work_nxt  = r_work;
        w_out_nxt   = r_out;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_bus.start) begin
                    w_capture   = 1'b1;
                    w_work_nxt  = if_bus.in;
                    w_stage_nxt = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_work_nxt  = w_stage_res;
                w_stage_nxt = STAGE_W'(r_stage + STAGE_W'(1));
                if (r_stage == LAST_STAGE) begin
                    w_out_nxt   = w_stage_res;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_stage_nxt = '0;
            end
        endcase
    end

    // State, datapath and status registers; busy/done track the next state so they
    // are flops that mirror the FSM state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_work  <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_work  <= w_work_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_capture) begin
                r_cnt  <= if_bus.cnt;
                r_op   <= if_bus.op;
                r_sign <= if_bus.in[DATA_W-1];
            end
        end
    end

    assign if_bus.out  = r_out;
    assign if_bus.busy = r_busy;
    assign if_bus.done = r_done;

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 16 bits, shift amount fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 in  input  16  operand; captured when start is accepted.
REQ-006 cnt  input  4  shift/rotate amount 0..15; captured with in.
REQ-007 op  input  2  00 rotate right, 01 logical shift right, 10 arithmetic shift right, 11 rotate right; captured with in.
REQ-008 out  output  16  registered result; holds last result until next completion.
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  1  one-cycle completion pulse, high only in DONE state.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE, plus a 2-bit stage counter.
REQ-012 IDLE: start=1 at a rising edge -> capture in/cnt/op into internal work registers, stage<=0, go RUN; start=0 -> stay IDLE.
REQ-013 RUN: each edge applies stage k (k=stage) to the work register: if captured cnt[k]=1, move right by 2^k bits; otherwise unchanged; then stage<=stage+1.
REQ-014 Stage fill bits: rotate -> bits leaving at bit 0 re-enter at bit 15; logical -> zeros; arithmetic -> copies of captured in[15].
REQ-015 On the edge processing stage 3: out<=final result, state<=DONE; stage counter wraps to 0.
REQ-016 DONE: done=1, busy=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-017 Latency fixed: done high in the 5th cycle after the accepting edge (4 RUN edges), independent of cnt and op.
REQ-018 cnt=0 SHALL still take full latency and produce out equal to captured in.
REQ-019 start asserted in RUN or DONE SHALL be ignored; no queuing; in/cnt/op changes during RUN SHALL not affect the result.
REQ-020 start held high continuously SHALL yield back-to-back operations with one IDLE cycle between each done pulse and next acceptance.
REQ-021 out SHALL change only on the stage-3 edge or reset; never shows intermediate stage values.
REQ-022 done and busy SHALL be decoded directly from state registers (glitch-free, no combinational path from inputs).

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, stage=0, out=16'h0000, work registers=0, busy=0, done=0, regardless of clock.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation; no done pulse is produced for it.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-026 op=00, in=16'h1234, cnt=4, start pulse -> done 5 cycles later, out=16'h4123, busy high for 5 cycles.
REQ-027 op=01, in=16'h8001, cnt=15 -> out=16'h0001; op=10, in=16'h8000, cnt=15 -> out=16'hFFFF; op=10, in=16'h7FF0, cnt=4 -> out=16'h07FF.
REQ-028 op=00, in=16'h00FF, cnt=8 -> out=16'hFF00; op=11, same operands -> out=16'hFF00; cnt=0 with in=16'hA5A5, any op -> out=16'hA5A5 after full latency.
REQ-029 Start accepted, then in/cnt/op changed and start re-pulsed during RUN -> single done, result from first operands only.
REQ-030 rst_n pulsed low during 3rd RUN cycle -> out=0, busy=0, done never asserts for aborted op; new start afterward completes correctly.
REQ-031 start held high for 20 cycles with in=16'h0001, op=00, cnt=1 -> done pulses every 6 cycles, out=16'h8000 each time.
